mem_perf_snapshot_ctrl: RTL and testbench

- Captures an atomic snapshot of all memory-subsystem performance counters (icache, dcache, l2, l3, smem, mem) in one cycle.
- Streams the snapshot out one counter per beat over a valid/ready port to the CSR/DCR readout path.
- Triggered by software request or by a programmable periodic interval.
- Sits between the perf counter bundle outputs and the perf readout/trace logic.

---
 rtl/mem_perf_snapshot_ctrl_pkg.sv | 32 +++
 rtl/mem_perf_snapshot_ctrl_interval_timer.sv | 35 +++
 rtl/mem_perf_snapshot_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_perf_snapshot_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_perf_snapshot_ctrl_pkg.sv
// Shared types and constants for the memory perf-counter snapshot controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_perf_snapshot_ctrl_pkg;

   // Source slots within the flattened counter bundle
   localparam int PERF_SRC_ICACHE = 0;
   localparam int PERF_SRC_DCACHE = 1;
   localparam int PERF_SRC_L2     = 2;
   localparam int PERF_SRC_L3     = 3;
   localparam int PERF_SRC_SMEM   = 4;
   localparam int PERF_SRC_MEM    = 5;

   localparam int PERF_SNAP_NUM_SRCS = PERF_SRC_MEM + 1;
   localparam int PERF_SNAP_NUM_CTRS = 8;
   localparam int PERF_CTR_BITS      = 44;
   localparam int PERF_SNAP_SRC_BITS = $clog2(PERF_SNAP_NUM_SRCS);
   localparam int PERF_SNAP_IDX_BITS = $clog2(PERF_SNAP_NUM_CTRS);
   localparam int DROP_CNT_W         = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      STREAM  = 2'd2
   } perf_snap_state_e;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_perf_snapshot_ctrl_interval_timer.sv
// Periodic trigger: free-running interval counter that pulses expire every intv_cycles cycles.
// Latency: expire is combinational from the count; first expiry intv_cycles-1 cycles after enable.
// Backpressure: none; expiries are single-cycle pulses, the parent decides whether to keep them.
module perf_interval_timer #(
   parameter int INTV_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              intv_en,
   input  logic [INTV_W-1:0] intv_cycles,
   output logic              expire
);

   logic [INTV_W-1:0] count;
   logic              active;

   // A zero period disables the timer without clearing it
   assign active = intv_en && (intv_cycles != '0);
   assign expire = active && (count == intv_cycles - INTV_W'(1));

   // Count up while active; wrap on expiry, or silently when the period shrank below the count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!intv_en) begin
         count <= '0;
      end else if (active) begin
         if (expire || (count >= intv_cycles))
            count <= '0;
         else
            count <= count + INTV_W'(1);
      end
   end

endmodule

// File: rtl/mem_perf_snapshot_ctrl.sv
// Atomic one-cycle snapshot of all memory-subsystem perf counters, streamed out one counter per beat.
// Latency: request accepted in cycle T, capture at the end of T+1, first beat valid in T+2; full drain NUM_SRCS*NUM_CTRS beats.
// Backpressure: rsp_* hold while rsp_valid && !rsp_ready; periodic triggers while busy queue 1-deep, extras are dropped and counted.
module mem_perf_snapshot_ctrl
   import mem_perf_snapshot_ctrl_pkg::*;
#(
   parameter int NUM_SRCS = PERF_SNAP_NUM_SRCS,
   parameter int NUM_CTRS = PERF_SNAP_NUM_CTRS,
   parameter int CTR_W    = PERF_CTR_BITS,
   parameter int INTV_W   = 32,
   localparam int SRC_W   = $clog2(NUM_SRCS),
   localparam int IDX_W   = $clog2(NUM_CTRS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_SRCS*NUM_CTRS*CTR_W-1:0] ctr_in,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             intv_en,
   input  logic [INTV_W-1:0]                intv_cycles,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [CTR_W-1:0]                 rsp_data,
   output logic [SRC_W-1:0]                 rsp_src,
   output logic [IDX_W-1:0]                 rsp_idx,
   output logic                             rsp_last,
   output logic                             busy,
   output logic [DROP_CNT_W-1:0]            drop_cnt
);

   perf_snap_state_e state, state_nxt;

   logic [CTR_W-1:0] snap [NUM_SRCS][NUM_CTRS];
   logic [SRC_W-1:0] src_ptr;
   logic [IDX_W-1:0] idx_ptr;
   logic             pending;
   logic             intv_expire;
   logic             beat_last;
   logic             in_stream;

   perf_interval_timer #(
      .INTV_W (INTV_W)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .intv_en     (intv_en),
      .intv_cycles (intv_cycles),
      .expire      (intv_expire)
   );

   assign in_stream = (state == STREAM);
   assign beat_last = (src_ptr == SRC_W'(NUM_SRCS - 1)) && (idx_ptr == IDX_W'(NUM_CTRS - 1));
   assign busy      = (state != IDLE);
   assign rsp_last  = in_stream && beat_last;
   assign rsp_src   = in_stream ? src_ptr : '0;
   assign rsp_idx   = in_stream ? idx_ptr : '0;
   assign rsp_data  = in_stream ? snap[src_ptr][idx_ptr] : '0;

   // State register; reset forces IDLE asynchronously so an in-flight stream vanishes at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state and handshake outputs; req_ready is held low while reset is asserted
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = !reset;
            if (req_valid || pending || intv_expire)
               state_nxt = CAPTURE;
         end
         CAPTURE: begin
            state_nxt = STREAM;
         end
         STREAM: begin
            rsp_valid = 1'b1;
            if (rsp_ready && beat_last)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Latch every live counter on the single CAPTURE edge; held untouched while streaming
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SRCS; s++)
            for (int c = 0; c < NUM_CTRS; c++)
               snap[s][c] <= '0;
      end else if (state == CAPTURE) begin
         for (int s = 0; s < NUM_SRCS; s++)
            for (int c = 0; c < NUM_CTRS; c++)
               snap[s][c] <= ctr_in[(s*NUM_CTRS + c)*CTR_W +: CTR_W];
      end
   end

   // Beat pointer: counter index inner, source index outer, back to zero after the last beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_ptr <= '0;
         idx_ptr <= '0;
      end else if (state == CAPTURE) begin
         src_ptr <= '0;
         idx_ptr <= '0;
      end else if (in_stream && rsp_ready) begin
         if (idx_ptr == IDX_W'(NUM_CTRS - 1)) begin
            idx_ptr <= '0;
            src_ptr <= beat_last ? '0 : src_ptr + 1'b1;
         end else begin
            idx_ptr <= idx_ptr + 1'b1;
         end
      end
   end

   // Periodic expiries while busy: first one is remembered, later ones are counted as drops
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= 1'b0;
         drop_cnt <= '0;
      end else if (!intv_en) begin
         pending <= 1'b0;
      end else if (state == CAPTURE) begin
         pending <= intv_expire;
      end else if (in_stream && intv_expire) begin
         if (pending)
            drop_cnt <= sat_inc(drop_cnt);
         else
            pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_perf_snapshot_ctrl.sv
module tb_mem_perf_snapshot_ctrl;

   localparam int NS = 6;
   localparam int NC = 8;
   localparam int CW = 44;
   localparam int IW = 32;
   localparam int NB = NS * NC;

   logic              clk = 1'b0;
   logic              reset;
   logic [NB*CW-1:0]  ctr_in;
   logic              req_valid, req_ready, intv_en;
   logic [IW-1:0]     intv_cycles;
   logic              rsp_valid, rsp_ready, rsp_last, busy;
   logic [CW-1:0]     rsp_data;
   logic [2:0]        rsp_src, rsp_idx;
   logic [15:0]       drop_cnt;

   logic [CW-1:0] ctr      [NB];
   logic [CW-1:0] exp_snap [NB];
   logic [CW-1:0] obs_data [NB];
   logic [2:0]    obs_src  [NB];
   logic [2:0]    obs_idx  [NB];
   logic          obs_last [NB];

   typedef struct {
      int         beat;
      logic [2:0] src;
      logic [2:0] idx;
      logic       last;
   } beat_vec_t;
   beat_vec_t tbl [6];

   int n_checks = 0;
   int n_fail   = 0;
   int rises[$];
   int exp_rises[$];
   int hs, first_rise, busy_cycles, n_exp, exp_drop, chg_cycle;
   logic prev_busy;

   always #5 clk = ~clk;

   always_comb begin
      ctr_in = '0;
      for (int i = 0; i < NB; i++)
         ctr_in[i*CW +: CW] = ctr[i];
   end

   mem_perf_snapshot_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .ctr_in      (ctr_in),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .intv_en     (intv_en),
      .intv_cycles (intv_cycles),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_src     (rsp_src),
      .rsp_idx     (rsp_idx),
      .rsp_last    (rsp_last),
      .busy        (busy),
      .drop_cnt    (drop_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] r44();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[CW-1:0];
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NB; i++)
         ctr[i] = r44();
   endtask

   task automatic timer_off();
      intv_en     = 1'b0;
      intv_cycles = '0;
      tick();
      tick();
   endtask

   // mode 0: ready high; 1: random ready; 2: ready high and live counters move every cycle
   task automatic drain(input int mode, input int stop_at, input string tag);
      int k = 0;
      int cyc = 0;
      logic [51:0] e;
      while (k < stop_at && cyc < 400) begin
         rsp_ready = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (mode == 2)
            for (int i = 0; i < NB; i++) ctr[i] = ctr[i] + 1'b1;
         @(negedge clk);
         e = {1'b1, 3'(k / NC), 3'(k % NC), (k == NB - 1), exp_snap[k]};
         check($sformatf("%s beat %0d", tag, k),
               {rsp_valid, rsp_src, rsp_idx, rsp_last, rsp_data}, e);
         obs_data[k] = rsp_data;
         obs_src[k]  = rsp_src;
         obs_idx[k]  = rsp_idx;
         obs_last[k] = rsp_last;
         if (rsp_valid && rsp_ready) k++;
         cyc++;
         tick();
      end
      check({tag, " beats handshaken"}, k, stop_at);
      if (stop_at == NB) begin
         rsp_ready = 1'b1;
         @(negedge clk);
         check({tag, " idle after last"}, {busy, rsp_valid}, 2'b00);
         tick();
      end
   endtask

   task automatic snapshot_req(input int mode, input int stop_at, input string tag);
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, " req_ready"}, req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      if (mode == 2)
         for (int i = 0; i < NB; i++) ctr[i] = ctr[i] + 1'b1;
      for (int i = 0; i < NB; i++) exp_snap[i] = ctr[i];
      @(negedge clk);
      check({tag, " capture cycle busy/valid/ready"}, {busy, rsp_valid, req_ready}, 3'b100);
      tick();
      drain(mode, stop_at, tag);
   endtask

   task automatic idle_wait(input string tag);
      int n = 0;
      rsp_ready = 1'b1;
      @(negedge clk);
      while (busy && n < 200) begin
         tick();
         @(negedge clk);
         n++;
      end
      check({tag, " idle wait"}, busy, 1'b0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{0,  3'd0, 3'd0, 1'b0};
      tbl[1] = '{7,  3'd0, 3'd7, 1'b0};
      tbl[2] = '{8,  3'd1, 3'd0, 1'b0};
      tbl[3] = '{19, 3'd2, 3'd3, 1'b0};
      tbl[4] = '{40, 3'd5, 3'd0, 1'b0};
      tbl[5] = '{47, 3'd5, 3'd7, 1'b1};

      reset = 1'b1; req_valid = 1'b0; intv_en = 1'b0; intv_cycles = '0; rsp_ready = 1'b0;
      for (int i = 0; i < NB; i++) ctr[i] = '0;
      @(negedge clk);
      check("reset outputs", {req_ready, rsp_valid, rsp_last, busy, rsp_src, rsp_idx, drop_cnt}, 64'd0);
      check("reset rsp_data", rsp_data, 64'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("idle after reset", {req_ready, busy, rsp_valid}, 3'b100);
      tick();

      // Basic snapshot, then table of beat positions
      fill_random();
      ctr[19] = 44'h123;
      rsp_ready = 1'b1;
      snapshot_req(0, NB, "basic");
      for (int i = 0; i < 6; i++)
         check($sformatf("table beat %0d src/idx/last", tbl[i].beat),
               {obs_src[tbl[i].beat], obs_idx[tbl[i].beat], obs_last[tbl[i].beat]},
               {tbl[i].src, tbl[i].idx, tbl[i].last});
      check("basic beat19 data", obs_data[19], 44'h123);

      // Atomicity: live counters move every cycle after the capture edge
      fill_random();
      snapshot_req(2, NB, "atomic");

      // Random backpressure
      for (int r = 0; r < 3; r++) begin
         fill_random();
         snapshot_req(1, NB, $sformatf("backpressure%0d", r));
      end

      // Periodic trigger, period 100, never stalled
      rsp_ready = 1'b1;
      intv_cycles = 100;
      intv_en = 1'b1;
      rises.delete();
      hs = 0;
      prev_busy = 1'b0;
      for (int c = 0; c < 360; c++) begin
         @(negedge clk);
         if (busy && !prev_busy) rises.push_back(c);
         prev_busy = busy;
         if (rsp_valid && rsp_ready) hs++;
         tick();
      end
      timer_off();
      exp_rises.delete();
      for (int c = 100; c < 360; c += 100) exp_rises.push_back(c);
      check("periodic snapshot count", rises.size(), exp_rises.size());
      for (int i = 0; i < exp_rises.size() && i < rises.size(); i++)
         check($sformatf("periodic capture %0d cycle", i), rises[i], exp_rises[i]);
      check("periodic handshakes", hs, NB * exp_rises.size());
      check("periodic drop_cnt", drop_cnt, 16'd0);

      // Request coinciding with an expiry: one snapshot, nothing left pending
      fill_random();
      intv_cycles = 60;
      intv_en = 1'b1;
      repeat (59) tick();
      snapshot_req(0, NB, "simul");
      busy_cycles = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         tick();
      end
      check("simul no second snapshot", busy_cycles, 0);
      check("simul drop_cnt", drop_cnt, 16'd0);
      timer_off();

      // Shrinking the period below the running count wraps without an expiry
      intv_cycles = 50;
      intv_en = 1'b1;
      repeat (30) tick();
      chg_cycle = 30;
      intv_cycles = 20;
      first_rise = -1;
      prev_busy = 1'b0;
      for (int c = chg_cycle; c < 80; c++) begin
         @(negedge clk);
         if (busy && !prev_busy && first_rise < 0) first_rise = c;
         prev_busy = busy;
         tick();
      end
      check("period change capture cycle", first_rise, chg_cycle + 20 + 1);
      intv_en = 1'b0;
      idle_wait("period change");
      timer_off();

      // Overrun: period 10, consumer stalled for 100 cycles
      fill_random();
      rsp_ready = 1'b0;
      intv_cycles = 10;
      intv_en = 1'b1;
      repeat (10) tick();
      for (int i = 0; i < NB; i++) exp_snap[i] = ctr[i];
      @(negedge clk);
      check("overrun capture", {busy, rsp_valid}, 2'b10);
      tick();
      for (int c = 11; c < 110; c++) begin
         @(negedge clk);
         check($sformatf("overrun stall cycle %0d", c),
               {rsp_valid, rsp_src, rsp_idx, rsp_last, rsp_data},
               {1'b1, 3'd0, 3'd0, 1'b0, exp_snap[0]});
         tick();
      end
      intv_cycles = 0;
      n_exp = 0;
      for (int t = 11; t <= 110; t++)
         if (t < 110 && (t % 10) == 9) n_exp++;
      exp_drop = n_exp - 1;
      @(negedge clk);
      check("overrun drop_cnt", drop_cnt, exp_drop);
      tick();
      drain(0, NB, "overrun first");
      @(negedge clk);
      check("overrun pending capture", {busy, rsp_valid}, 2'b10);
      tick();
      drain(0, NB, "overrun second");
      check("overrun drop_cnt kept", drop_cnt, exp_drop);
      timer_off();

      // Reset in the middle of a stream
      fill_random();
      rsp_ready = 1'b1;
      snapshot_req(0, 20, "rst");
      reset = 1'b1;
      #1;
      check("reset mid-stream async", {rsp_valid, busy, req_ready, rsp_last}, 4'b0000);
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("after reset busy/ready/drop", {busy, req_ready, drop_cnt}, {1'b0, 1'b1, 16'd0});
      tick();
      fill_random();
      snapshot_req(0, NB, "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
